// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Mid-bit sampling from a start-edge aligned
// bit counter, one-entry holding register with read strobe, framing-error
// pulse and sticky overrun flag.
module uart_rx #(
    parameter logic [9:0] DIV_CNT  = 10'd867,  // clocks per bit minus 1
    parameter logic [9:0] HDIV_CNT = 10'd433,  // start edge to start mid-point, minus 1
    parameter logic [3:0] RX_BITS  = 4'd8      // data bits per frame (fixed at 8)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_rd,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [3:0] LastBit = RX_BITS - 4'd1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e     state_q, state_d;
    logic [9:0] div_cnt_q, div_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sync1_q, sync2_q;
    logic       rx_prev_q, rx_prev_d;
    logic [1:0] fill_q;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic rx_s, start_edge, rd_ok, frame_done, frame_bad;

    // Frame sequencing: edge detect, mid-bit sampling and stop-bit check.
    always_comb begin
        rx_s       = sync2_q;
        start_edge = rx_prev_q & ~rx_s;
        // rx_prev only tracks real line samples once the synchronizer has
        // flushed its reset value, so a line held low through reset never
        // looks like a falling edge.
        rx_prev_d  = fill_q[1] & rx_s;

        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        frame_bad  = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_cnt_d = 10'd0;
                if (start_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (div_cnt_q == HDIV_CNT) begin
                    div_cnt_d = 10'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = rx_s ? StIdle : StData;
                end else begin
                    div_cnt_d = div_cnt_q + 10'd1;
                end
            end
            StData: begin
                if (div_cnt_q == DIV_CNT) begin
                    div_cnt_d = 10'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 10'd1;
                end
            end
            StStop: begin
                if (div_cnt_q == DIV_CNT) begin
                    div_cnt_d  = 10'd0;
                    state_d    = StIdle;
                    frame_done = rx_s;
                    frame_bad  = ~rx_s;
                end else begin
                    div_cnt_d = div_cnt_q + 10'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register handshake; a completing byte wins over a same-cycle read.
    always_comb begin
        rd_ok       = rx_rd & rx_valid_q;
        rx_data_d   = frame_done ? shift_q : rx_data_q;
        rx_valid_d  = frame_done | (rx_valid_q & ~rd_ok);
        overrun_d   = (frame_done & rx_valid_q & ~rx_rd) | (overrun_q & ~rd_ok);
        frame_err_d = frame_bad;
    end

    // All state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            div_cnt_q   <= 10'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b0;
            fill_q      <= 2'b00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            rx_prev_q   <= rx_prev_d;
            fill_q      <= {fill_q[0], 1'b1};
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model and per-cycle compare for uart_rx.
// The DUT runs with a shortened bit period so the whole run stays small;
// all expected timing is derived from the same two divider values.
module tb_uart_rx;

    localparam logic [9:0] Div  = 10'd99;
    localparam logic [9:0] HDiv = 10'd49;
    localparam int Bit = 100;                       // Div + 1
    localparam int Lat = 3 + 50 + 9 * Bit;          // pin edge to rx_valid

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         good;
    } ev_t;

    ev_t pend[$];
    int  rd_q[$];

    // model of the holding register as seen after each clock edge
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         last_at = -100;
    bit         last_good = 1'b1;
    int         fe_cnt = 0;

    // observation helpers for the directed literal checks
    int         rise_n = 0;
    int         rise_cyc = 0;
    int         fe_total = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] got_q[$];

    uart_rx #(.DIV_CNT(Div), .HDIV_CNT(HDiv), .RX_BITS(4'd8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_rd    (rx_rd),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; the model learns when its byte (or framing error) lands.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit track);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (track) pend.push_back('{at: cyc + Lat, data: b, good: stop});
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_cyc(Bit);
        end
        if (!stop) begin
            rx = 1'b1;
            wait_cyc(Bit);
        end
    endtask

    task automatic pulse_rd();
        rd_q.push_back(cyc + 1);
        wait_cyc(3);
    endtask

    // Read-strobe driver: one-cycle pulses at requested cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (rd_q.size() > 0 && rd_q[0] < cyc) void'(rd_q.pop_front());
            if (rd_q.size() > 0 && rd_q[0] == cyc) begin
                rx_rd = 1'b1;
                void'(rd_q.pop_front());
            end else begin
                rx_rd = 1'b0;
            end
        end
    end

    // Observation of rises and error pulses for the directed checks.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && valid_prev !== 1'b1) begin
            rise_n++;
            rise_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (frame_err === 1'b1) fe_total++;
        valid_prev = rx_valid;
    end

    // Per-cycle compare against the model, then advance the model one edge.
    always @(negedge clk) begin
        bit in_win;
        bit rd_ok;
        bit good_now;
        // +-3 clock tolerance around each frame completion
        in_win = (pend.size() > 0 && cyc + 3 >= pend[0].at) || (cyc <= last_at + 3);
        if (pend.size() > 0 && cyc + 3 == pend[0].at) fe_cnt = 0;
        if (in_win) begin
            if (frame_err === 1'b1) fe_cnt++;
        end else begin
            check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
            check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            check("frame_err_quiet", {31'd0, frame_err}, 32'd0);
        end
        if (cyc == last_at + 4) check("frame_err_pulses", fe_cnt, last_good ? 32'd0 : 32'd1);

        if (rst === 1'b0) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovr   = 1'b0;
            pend.delete();
        end else begin
            rd_ok    = rx_rd && m_valid;
            good_now = 1'b0;
            if (pend.size() > 0 && pend[0].at == cyc + 1) begin
                last_at   = pend[0].at;
                last_good = pend[0].good;
                if (pend[0].good) begin
                    good_now = 1'b1;
                    if (m_valid && !rx_rd) m_ovr = 1'b1;
                    else if (rd_ok) m_ovr = 1'b0;
                    m_data  = pend[0].data;
                    m_valid = 1'b1;
                end
                void'(pend.pop_front());
            end
            if (!good_now && rd_ok) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    end

    initial begin
        int s, lat, n0, r0, f0;
        logic [9:0] bits;

        // reset with the line toggling
        @(posedge clk);
        #1;
        repeat (5) begin
            rx = ~rx;
            wait_cyc(1);
        end
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rx  = 1'b1;
        rst = 1'b1;
        wait_cyc(20000);
        check("idle_no_valid", rise_n, 32'd0);

        // single byte, latency and read
        s = cyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        lat = rise_cyc - s;
        total++;
        if (rise_n != 1 || lat < Lat - 3 || lat > Lat + 3) begin
            bad++;
            $display("FAIL latency: got %0d (rises %0d) want %0d+-3", lat, rise_n, Lat);
        end
        check("single_data", {24'd0, rx_data}, 32'hA5);
        pulse_rd();
        check("single_rd_clears", {31'd0, rx_valid}, 32'd0);
        check("single_data_hold", {24'd0, rx_data}, 32'hA5);

        // back-to-back frames with a read after each
        n0 = got_q.size();
        f0 = fe_total;
        s  = cyc;
        for (int i = 0; i < 3; i++) rd_q.push_back(s + Lat + i * 10 * Bit + 20);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_cyc(100);
        check("b2b_count", got_q.size() - n0, 32'd3);
        check("b2b_byte0", {24'd0, (got_q.size() > n0) ? got_q[n0] : 8'hxx}, 32'h00);
        check("b2b_byte1", {24'd0, (got_q.size() > n0 + 1) ? got_q[n0 + 1] : 8'hxx}, 32'hFF);
        check("b2b_byte2", {24'd0, (got_q.size() > n0 + 2) ? got_q[n0 + 2] : 8'hxx}, 32'h55);
        check("b2b_frame_err", fe_total - f0, 32'd0);
        check("b2b_overrun", {31'd0, overrun}, 32'd0);

        // short low glitch is rejected
        r0 = rise_n;
        rx = 1'b0;
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(2000);
        check("glitch_no_valid", rise_n - r0, 32'd0);
        check("glitch_no_ferr", fe_total - f0, 32'd0);

        // bad stop bit, then the same byte correctly framed
        send_frame(8'h3C, 1'b0, 1'b1);
        check("ferr_one_cycle", fe_total - f0, 32'd1);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1);
        check("after_ferr_data", {24'd0, rx_data}, 32'h3C);
        check("after_ferr_valid", {31'd0, rx_valid}, 32'd1);
        pulse_rd();

        // overrun without read, then read in the completion cycle
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        check("ovr_data", {24'd0, rx_data}, 32'h22);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        pulse_rd();
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        check("ovr_valid_cleared", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h11, 1'b1, 1'b1);
        rd_q.push_back(cyc + Lat - 1);
        send_frame(8'h22, 1'b1, 1'b1);
        check("sim_rd_no_ovr", {31'd0, overrun}, 32'd0);
        check("sim_rd_valid", {31'd0, rx_valid}, 32'd1);
        check("sim_rd_data", {24'd0, rx_data}, 32'h22);
        pulse_rd();

        // reset during data bit 4 of 0x96, released while bit 5 holds the line low
        r0   = rise_n;
        f0   = fe_total;
        bits = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            wait_cyc(Bit);
        end
        rx = bits[5];
        wait_cyc(Bit / 2);
        rst = 1'b0;
        wait_cyc(Bit / 2);
        rx = bits[6];
        wait_cyc(Bit / 2);
        rst = 1'b1;
        wait_cyc(Bit / 2);
        for (int i = 7; i < 10; i++) begin
            rx = bits[i];
            wait_cyc(Bit);
        end
        wait_cyc(2000);
        check("rstmid_no_valid", rise_n - r0, 32'd0);
        check("rstmid_no_ferr", fe_total - f0, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("rstmid_next_data", {24'd0, rx_data}, 32'h5A);
        check("rstmid_next_valid", {31'd0, rx_valid}, 32'd1);
        pulse_rd();

        // random frames, gaps, reads and bad stop bits against the model
        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b1);
            if ($urandom_range(0, 1) == 1) pulse_rd();
            wait_cyc($urandom_range(0, 300));
        end

        wait_cyc(50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the board's existing UART transmitter.
- Runs at the same bit timing: 100 MHz clock, 115200 baud, 868 clocks per bit.
- Oversamples the serial line, checks the start bit at its mid-point, samples 8 data bits LSB first, checks the stop bit, and presents each byte in a one-entry holding register.
- The consumer (LED/switch logic, or a loopback into the transmitter) acknowledges the byte with a read strobe.

Parameters:
- DIV_CNT, 10'd867: clocks per bit minus 1. Bit period = DIV_CNT+1 clocks.
- HDIV_CNT, 10'd433: clocks from detected start edge to start-bit mid-point, minus 1.
- RX_BITS, 4'd8: data bits per frame. Fixed at 8; the parameter exists for readability only.

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- rx  input  1  serial line from host, asynchronous to clk, idles high.
- rx_data  output  8  last received byte, valid while rx_valid=1.
- rx_valid  output  1  holding register full; level, not pulse.
- rx_rd  input  1  consumer read strobe; one-cycle pulse clears rx_valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte completed while rx_valid=1 and rx_rd=0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; div_cnt=0; bit_cnt=0; shift register=0.
  - Both synchronizer flops=1.
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
  - A frame in progress is discarded.
- Input conditioning:
  - Two-flop synchronizer rx -> rx_s.
  - Start edge = rx_s_prev=1 and rx_s=0.
  - A line held low through reset release produces no edge. It must go high, then low, to start a frame.
- State machine (div_cnt counts 0..N, then resets to 0; div_cnt=0 in IDLE):
  - IDLE: on start edge -> START, div_cnt=0.
  - START: count to HDIV_CNT. At div_cnt==HDIV_CNT: if rx_s=0 -> DATA, div_cnt=0, bit_cnt=0; else -> IDLE (glitch rejected, no outputs change).
  - DATA: count to DIV_CNT. At div_cnt==DIV_CNT: shift rx_s into the MSB of shift register (right shift, so the first bit received ends up in bit 0); bit_cnt++. When bit_cnt reaches 8 -> STOP.
  - STOP: at div_cnt==DIV_CNT, sample rx_s.
    - rx_s=1: rx_data<=shift, rx_valid<=1, -> IDLE.
    - rx_s=0: frame_err pulses 1 cycle, data discarded, rx_valid/rx_data unchanged, -> IDLE.
    - A line held low (break) produces no new start edge, so there is no re-trigger until the line returns high.
- Sample points: every sample is taken at bit mid-point ±1 clock, plus 2-3 clocks of synchronizer delay.
- Latency: rx_valid rises 8249 ±3 clocks after the rx pin falling edge of the start bit (3 + 434 + 9×868).
- Handshake:
  - rx_rd=1 with rx_valid=1 clears rx_valid on the next edge.
  - rx_rd with rx_valid=0 is ignored.
  - rx_data holds its value until the next good frame.
- Simultaneous events:
  - Byte completes in the same cycle as rx_rd=1: new byte loaded, rx_valid stays 1, overrun not set.
  - Byte completes with rx_valid=1 and rx_rd=0: new byte overwrites rx_data, overrun<=1.
  - overrun clears on the cycle rx_rd=1 is accepted, unless it is set in that same cycle (impossible per the rule above).
- Back-to-back frames: the state is back in IDLE by the stop-bit mid-point, so the next start edge, even with zero idle time, is detected.
- Counters never wrap: div_cnt is 10-bit, max 867; bit_cnt is 4-bit, max 8.

Test Plan:
- Reset: hold rst=0 for 5 clocks with rx toggling -> all outputs 0; no rx_valid within 20000 clocks after release with rx=1.
- Single byte: send 0xA5 at 868 clk/bit -> rx_valid rises 8249±3 clocks after the start edge with rx_data=8'hA5; pulse rx_rd -> rx_valid=0 next cycle, rx_data still 8'hA5.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle bits, issuing rx_rd after each -> three rx_valid assertions with data 00, FF, 55; frame_err=0, overrun=0.
- Glitch and framing:
  - Drive rx low for 200 clocks -> no state change, no outputs.
  - Send 0x3C with the stop bit low -> frame_err pulses exactly 1 cycle, rx_valid stays 0.
  - Then send 0x3C normally -> received correctly.
- Overrun: send 0x11, then 0x22 without rx_rd -> rx_data=8'h22, overrun=1; rx_rd -> overrun=0, rx_valid=0. Repeat with rx_rd asserted in the completion cycle of the second byte -> overrun stays 0, rx_valid stays 1.
- Reset mid-frame: assert rst=0 during data bit 4 of 0x96, release with rx still in frame -> no rx_valid or frame_err from that frame; the next full frame 0x5A is received correctly.
